// File: rtl/ram_pkg.sv
// ----------------------------------------------------------------------------
// ram_pkg
// Shared definitions for the single-port byte-write RAM with clear engine:
//   - write-mode encodings (READ_FIRST / WRITE_FIRST / NO_CHANGE)
//   - log2 helper used to size address buses (minimum width of 1)
//   - clear-engine FSM state encoding
// ----------------------------------------------------------------------------
package ram_pkg;

    localparam int WM_READ_FIRST  = 0;
    localparam int WM_WRITE_FIRST = 1;
    localparam int WM_NO_CHANGE   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    // Ceiling log2; a depth of 1 still gets a 1-bit address.
    function automatic int log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// ----------------------------------------------------------------------------
// ram_clear_ctrl
// Clear-engine FSM and sweep counter. While in CLEAR it owns the array write
// port and writes every address 0..DEPTH-1 once, one word per cycle.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-low reset
//   i_clr        clear request, honoured only while o_ready is high
//   o_ready      user accesses accepted (IDLE and not in the boot cycle)
//   o_clr_we     array write strobe from the sweep
//   o_clr_addr   sweep address
//   o_clr_sel    array port select: 1 = sweep, 0 = user
//   o_state      current FSM state (debug visibility)
// ----------------------------------------------------------------------------
module ram_clear_ctrl
    import ram_pkg::*;
#(
    parameter int DEPTH          = 1024,
    parameter int AW             = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    output logic          o_ready,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr,
    output logic          o_clr_sel,
    output clr_state_e    o_state
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    clr_state_e    r_state;
    clr_state_e    w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;
    // High only in the first cycle after reset release; it lets the FSM
    // launch the automatic sweep on the first edge and keeps ready low
    // until that edge has happened.
    logic          r_boot;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_boot  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_boot  <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (r_boot) begin
                    if (CLEAR_ON_RESET) begin
                        w_state_nxt = ST_CLEAR;
                    end
                end else if (i_clr) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                // clr is not looked at here, so a request mid-sweep cannot
                // restart it.
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_ready    = (r_state == ST_IDLE) && !r_boot;
    assign o_clr_we   = (r_state == ST_CLEAR);
    assign o_clr_sel  = (r_state == ST_CLEAR);
    assign o_clr_addr = r_cnt;
    assign o_state    = r_state;

endmodule

// File: rtl/rams_sp_bw_clr.sv
// ----------------------------------------------------------------------------
// rams_sp_bw_clr
// Single-port RAM with per-byte write enables, selectable write mode,
// optional second output register and a hardware clear sweep.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset (array contents not reset)
//   clr         clear request, sampled only while ready
//   ready       user accesses accepted
//   en          access enable
//   we          per-byte write enables; all zero = read
//   addr        word address
//   di          write data
//   dout        read data, holds between results
//   dout_valid  one-cycle pulse per new dout
// ----------------------------------------------------------------------------
module rams_sp_bw_clr
    import ram_pkg::*;
#(
    parameter  int                    DATA_WIDTH     = 32,
    parameter  int                    DATA_DEPTH     = 1024,
    parameter  int                    BYTE_WIDTH     = 8,
    parameter  int                    WRITE_MODE     = WM_READ_FIRST,
    parameter  bit                    OUT_REG        = 1'b0,
    parameter  bit                    CLEAR_ON_RESET = 1'b1,
    parameter  logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
    localparam int                    NB             = DATA_WIDTH / BYTE_WIDTH,
    localparam int                    AW             = log2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    output logic                  ready,
    input  logic                  en,
    input  logic [NB-1:0]         we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] di,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid
);

    logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];

    logic                  w_clr_we;
    logic                  w_clr_sel;
    logic [AW-1:0]         w_clr_addr;
    clr_state_e            w_clr_state;

    logic                  w_accept;
    logic                  w_is_wr;
    logic                  w_in_range;
    logic                  w_wr_en;
    logic [AW-1:0]         w_idx;
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_rd_upd;

    logic [DATA_WIDTH-1:0] r_d1;
    logic                  r_v1;

    ram_clear_ctrl #(
        .DEPTH          (DATA_DEPTH),
        .AW             (AW),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_ctrl (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clr      (clr),
        .o_ready    (ready),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr),
        .o_clr_sel  (w_clr_sel),
        .o_state    (w_clr_state)
    );

    assign w_accept   = en && ready;
    assign w_is_wr    = |we;
    assign w_in_range = (int'(addr) < DATA_DEPTH);
    // Out-of-range addresses are folded to 0 so the array is never indexed
    // past its end; the result is masked or the write dropped below.
    assign w_idx      = w_in_range ? addr : '0;
    assign w_old      = r_mem[w_idx];
    assign w_wr_en    = w_accept && w_is_wr && w_in_range;

    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < NB; i++) begin
            if (we[i]) begin
                w_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = di[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // The sweep has priority; ready is low during it so no user write can
    // collide, the select just makes the ownership explicit.
    always_ff @(posedge clk) begin
        if (w_clr_sel) begin
            if (w_clr_we) begin
                r_mem[w_clr_addr] <= CLEAR_VALUE;
            end
        end else if (w_wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (we[i]) begin
                    r_mem[w_idx][i*BYTE_WIDTH +: BYTE_WIDTH] <= di[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_upd  = 1'b0;
        if (w_accept) begin
            if (!w_is_wr) begin
                w_rd_upd  = 1'b1;
                w_rd_data = w_in_range ? w_old : '0;
            end else if (WRITE_MODE == WM_WRITE_FIRST) begin
                w_rd_upd  = 1'b1;
                w_rd_data = w_in_range ? w_merged : '0;
            end else if (WRITE_MODE == WM_NO_CHANGE) begin
                w_rd_upd  = 1'b0;
            end else begin
                w_rd_upd  = 1'b1;
                w_rd_data = w_in_range ? w_old : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_d1 <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= w_rd_upd;
            if (w_rd_upd) begin
                r_d1 <= w_rd_data;
            end
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic [DATA_WIDTH-1:0] r_d2;
            logic                  r_v2;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_d2 <= '0;
                    r_v2 <= 1'b0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_d2 <= r_d1;
                    end
                end
            end
            assign dout       = r_d2;
            assign dout_valid = r_v2;
        end else begin : g_no_out_reg
            assign dout       = r_d1;
            assign dout_valid = r_v1;
        end
    endgenerate

endmodule

// File: tb/tb_rams_sp_bw_clr.sv
// ----------------------------------------------------------------------------
// tb_rams_sp_bw_clr
// Six DUT instances with different parameter sets share clk and rst:
//   0: defaults (1024 deep, READ_FIRST, no out reg, clear on reset, 0)
//   1: 16 deep, WRITE_FIRST
//   2: 16 deep, NO_CHANGE
//   3: 16 deep, OUT_REG = 1
//   4: 16 deep, CLEAR_VALUE = 0xFFFFFFFF
//   5: 12 deep, CLEAR_ON_RESET = 0 (exercises out-of-range addresses)
// Inputs are driven on the falling edge and outputs sampled on it.
// ----------------------------------------------------------------------------
module tb_rams_sp_bw_clr;

    localparam int NI = 6;

    logic        clk;
    logic        rst;
    logic        clr_a  [NI];
    logic        en_a   [NI];
    logic [3:0]  we_a   [NI];
    logic [9:0]  addr_a [NI];
    logic [31:0] di_a   [NI];
    logic        rdy_a  [NI];
    logic        dv_a   [NI];
    logic [31:0] dout_a [NI];

    int n_checks = 0;
    int n_err    = 0;

    function automatic int p_depth(input int g);
        if (g == 0) return 1024;
        if (g == 5) return 12;
        return 16;
    endfunction

    function automatic int p_mode(input int g);
        if (g == 1) return 1;
        if (g == 2) return 2;
        return 0;
    endfunction

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // ---------------- DUTs ----------------
    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int AWG = (g == 0) ? 10 : 4;
        rams_sp_bw_clr #(
            .DATA_WIDTH     (32),
            .DATA_DEPTH     (p_depth(g)),
            .BYTE_WIDTH     (8),
            .WRITE_MODE     (p_mode(g)),
            .OUT_REG        ((g == 3) ? 1'b1 : 1'b0),
            .CLEAR_ON_RESET ((g == 5) ? 1'b0 : 1'b1),
            .CLEAR_VALUE    ((g == 4) ? 32'hFFFF_FFFF : 32'h0)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .clr        (clr_a[g]),
            .ready      (rdy_a[g]),
            .en         (en_a[g]),
            .we         (we_a[g]),
            .addr       (addr_a[g][AWG-1:0]),
            .di         (di_a[g]),
            .dout       (dout_a[g]),
            .dout_valid (dv_a[g])
        );
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One-cycle access; entered and left on a falling edge.
    task automatic access(input int k, input logic e, input logic [3:0] w,
                          input logic [9:0] a, input logic [31:0] d);
        en_a[k]   = e;
        we_a[k]   = w;
        addr_a[k] = a;
        di_a[k]   = d;
        @(posedge clk);
        @(negedge clk);
        en_a[k] = 1'b0;
        we_a[k] = 4'h0;
    endtask

    typedef struct {
        int          k;
        logic        en;
        logic [3:0]  we;
        logic [9:0]  addr;
        logic [31:0] di;
        logic        exp_v;
        logic        chk_d;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vecs[$];

    // ---------------- test ----------------
    initial begin
        int cnt [NI];
        int exp_cnt [NI];
        int low;
        int dvs;
        int n;
        logic all_rdy;

        exp_cnt = '{1024, 16, 16, 16, 16, 0};

        //                k  en we    addr    di            v     chkd  exp_d
        vecs.push_back('{0, 1, 4'h0, 10'd0,    32'h0,        1'b1, 1'b1, 32'h0});
        vecs.push_back('{0, 1, 4'h0, 10'd511,  32'h0,        1'b1, 1'b1, 32'h0});
        vecs.push_back('{0, 1, 4'h0, 10'd1023, 32'h0,        1'b1, 1'b1, 32'h0});
        vecs.push_back('{0, 1, 4'hF, 10'd5,    32'hDEADBEEF, 1'b1, 1'b1, 32'h0});
        vecs.push_back('{0, 1, 4'h1, 10'd5,    32'h000000AA, 1'b1, 1'b1, 32'hDEADBEEF});
        vecs.push_back('{0, 1, 4'h0, 10'd5,    32'h0,        1'b1, 1'b1, 32'hDEADBEAA});
        vecs.push_back('{0, 1, 4'hF, 10'd7,    32'h11111111, 1'b1, 1'b1, 32'h0});
        vecs.push_back('{0, 1, 4'hF, 10'd7,    32'h22222222, 1'b1, 1'b1, 32'h11111111});
        vecs.push_back('{0, 1, 4'h0, 10'd7,    32'h0,        1'b1, 1'b1, 32'h22222222});
        vecs.push_back('{0, 0, 4'hF, 10'd5,    32'h0,        1'b0, 1'b1, 32'h22222222});
        vecs.push_back('{0, 1, 4'h0, 10'd5,    32'h0,        1'b1, 1'b1, 32'hDEADBEAA});
        vecs.push_back('{1, 1, 4'hF, 10'd7,    32'h11111111, 1'b1, 1'b1, 32'h11111111});
        vecs.push_back('{1, 1, 4'hF, 10'd7,    32'h22222222, 1'b1, 1'b1, 32'h22222222});
        vecs.push_back('{1, 1, 4'h1, 10'd7,    32'h000000AA, 1'b1, 1'b1, 32'h222222AA});
        vecs.push_back('{1, 1, 4'h0, 10'd7,    32'h0,        1'b1, 1'b1, 32'h222222AA});
        vecs.push_back('{2, 1, 4'h0, 10'd7,    32'h0,        1'b1, 1'b1, 32'h0});
        vecs.push_back('{2, 1, 4'hF, 10'd7,    32'h11111111, 1'b0, 1'b1, 32'h0});
        vecs.push_back('{2, 1, 4'h0, 10'd7,    32'h0,        1'b1, 1'b1, 32'h11111111});
        vecs.push_back('{2, 1, 4'hF, 10'd7,    32'h22222222, 1'b0, 1'b1, 32'h11111111});
        vecs.push_back('{2, 1, 4'h0, 10'd7,    32'h0,        1'b1, 1'b1, 32'h22222222});
        vecs.push_back('{5, 1, 4'hF, 10'd1,    32'hCAFEF00D, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{5, 1, 4'hF, 10'd13,   32'h12345678, 1'b1, 1'b1, 32'h0});
        vecs.push_back('{5, 1, 4'h0, 10'd13,   32'h0,        1'b1, 1'b1, 32'h0});
        vecs.push_back('{5, 1, 4'h0, 10'd1,    32'h0,        1'b1, 1'b1, 32'hCAFEF00D});
        vecs.push_back('{5, 1, 4'hF, 10'd11,   32'h0BADBEEF, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{5, 1, 4'h0, 10'd11,   32'h0,        1'b1, 1'b1, 32'h0BADBEEF});
        vecs.push_back('{5, 1, 4'h0, 10'd15,   32'h0,        1'b1, 1'b1, 32'h0});

        rst = 1'b0;
        for (int k = 0; k < NI; k++) begin
            clr_a[k] = 1'b0; en_a[k] = 1'b0; we_a[k] = 4'h0;
            addr_a[k] = 10'd0; di_a[k] = 32'h0;
        end

        // Reset state of every instance.
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("rst_ready_%0d", k), {31'b0, rdy_a[k]}, 32'h0);
            chk($sformatf("rst_dv_%0d", k),    {31'b0, dv_a[k]},  32'h0);
            chk($sformatf("rst_dout_%0d", k),  dout_a[k],         32'h0);
        end

        // Release, then abort the sweep part way through with rst.
        rst = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_dout_4",  dout_a[4],         32'h0);
        chk("abort_ready_4", {31'b0, rdy_a[4]}, 32'h0);
        chk("abort_dv_4",    {31'b0, dv_a[4]},  32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Count sampled cycles with ready low after release.
        for (int k = 0; k < NI; k++) cnt[k] = 0;
        for (int c = 0; c < 1200; c++) begin
            @(negedge clk);
            all_rdy = 1'b1;
            for (int k = 0; k < NI; k++) begin
                if (!rdy_a[k]) begin
                    cnt[k]++;
                    all_rdy = 1'b0;
                end
            end
            if (all_rdy) break;
        end
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("ready_low_cycles_%0d", k), cnt[k], exp_cnt[k]);
        end

        // Every word of instance 4 holds the clear value after the restarted sweep.
        for (int a = 0; a < 16; a++) begin
            access(4, 1'b1, 4'h0, 10'(a), 32'h0);
            chk($sformatf("sweep_word_%0d", a), dout_a[4], 32'hFFFF_FFFF);
        end
        chk("sweep_dv", {31'b0, dv_a[4]}, 32'h1);

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            access(vecs[i].k, vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].di);
            chk($sformatf("vec%0d_dv", i), {31'b0, dv_a[vecs[i].k]}, {31'b0, vecs[i].exp_v});
            if (vecs[i].chk_d) begin
                chk($sformatf("vec%0d_dout", i), dout_a[vecs[i].k], vecs[i].exp_d);
            end
        end

        // OUT_REG = 1: back-to-back reads, latency 2.
        access(3, 1'b1, 4'hF, 10'd1, 32'hA);
        access(3, 1'b1, 4'hF, 10'd2, 32'hB);
        access(3, 1'b1, 4'hF, 10'd3, 32'hC);
        access(3, 1'b0, 4'h0, 10'd0, 32'h0);
        en_a[3] = 1'b1; we_a[3] = 4'h0; addr_a[3] = 10'd1;
        @(posedge clk); @(negedge clk);
        chk("oreg_lat_dv", {31'b0, dv_a[3]}, 32'h0);
        addr_a[3] = 10'd2;
        @(posedge clk); @(negedge clk);
        chk("oreg_d1", dout_a[3], 32'hA);
        chk("oreg_v1", {31'b0, dv_a[3]}, 32'h1);
        addr_a[3] = 10'd3;
        @(posedge clk); @(negedge clk);
        chk("oreg_d2", dout_a[3], 32'hB);
        chk("oreg_v2", {31'b0, dv_a[3]}, 32'h1);
        en_a[3] = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("oreg_d3", dout_a[3], 32'hC);
        chk("oreg_v3", {31'b0, dv_a[3]}, 32'h1);
        @(posedge clk); @(negedge clk);
        chk("oreg_hold_d", dout_a[3], 32'hC);
        chk("oreg_hold_v", {31'b0, dv_a[3]}, 32'h0);

        // clr in IDLE together with a write; accesses during the sweep are ignored,
        // and a second clr mid-sweep must not restart it.
        clr_a[4] = 1'b1;
        en_a[4] = 1'b1; we_a[4] = 4'hF; addr_a[4] = 10'd3; di_a[4] = 32'h5;
        @(posedge clk); @(negedge clk);
        clr_a[4] = 1'b0;
        chk("clr_wr_dv",   {31'b0, dv_a[4]},  32'h1);
        chk("clr_wr_dout", dout_a[4],         32'hFFFF_FFFF);
        chk("clr_ready",   {31'b0, rdy_a[4]}, 32'h0);
        addr_a[4] = 10'd0; di_a[4] = 32'h77;
        low = 1; dvs = 0; n = 0;
        while (rdy_a[4] == 1'b0 && n < 100) begin
            clr_a[4] = (n == 5);
            @(negedge clk);
            n++;
            if (dv_a[4]) dvs++;
            if (!rdy_a[4]) low++;
        end
        clr_a[4] = 1'b0; en_a[4] = 1'b0; we_a[4] = 4'h0;
        chk("clr_low_cycles", low, 16);
        chk("clr_no_dv", dvs, 0);
        access(4, 1'b1, 4'h0, 10'd3, 32'h0);
        chk("clr_addr3", dout_a[4], 32'hFFFF_FFFF);
        access(4, 1'b1, 4'h0, 10'd0, 32'h0);
        chk("clr_addr0", dout_a[4], 32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
